// File: rtl/multi_alarm_clk_if.sv
// Port bundle for multi_alarm_clk: time/alarm programming inputs, snooze controls,
// and the registered display/buzzer outputs.
interface multi_alarm_clk_if #(
    parameter int NUM_ALARMS = 4,
    parameter int MAX_SNOOZE = 3,
    parameter int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
    parameter int SW = ($clog2(MAX_SNOOZE + 1) > 2) ? $clog2(MAX_SNOOZE + 1) : 2
);
    // No valid/ready handshake: every control input is a level sampled on each rising
    // Clock_1sec edge, so a LoadTime/LoadAlm pulse held for one cycle is consumed exactly once.
    logic          LoadTime;
    logic          Set_AM_PM;
    logic [5:0]    SetSecs;
    logic [5:0]    SetMins;
    logic [3:0]    SetHours;
    logic          LoadAlm;
    logic [AW-1:0] AlmSel;
    logic          AlmEnIn;
    logic          Alarm_AM_PM_In;
    logic [5:0]    AlarmMinsIn;
    logic [3:0]    AlarmHoursIn;
    logic          Snooze;
    logic          Dismiss;
    logic          AM_PM;
    logic [5:0]    Secs_C;
    logic [5:0]    Mins_C;
    logic [3:0]    Hours_C;
    logic          Alarm;
    logic [AW-1:0] AlarmId;
    logic [SW-1:0] SnoozeCnt;
    logic [1:0]    fsm_state;

    modport master (
        output LoadTime, Set_AM_PM, SetSecs, SetMins, SetHours,
        output LoadAlm, AlmSel, AlmEnIn, Alarm_AM_PM_In, AlarmMinsIn, AlarmHoursIn,
        output Snooze, Dismiss,
        input  AM_PM, Secs_C, Mins_C, Hours_C, Alarm, AlarmId, SnoozeCnt, fsm_state
    );

    modport slave (
        input  LoadTime, Set_AM_PM, SetSecs, SetMins, SetHours,
        input  LoadAlm, AlmSel, AlmEnIn, Alarm_AM_PM_In, AlarmMinsIn, AlarmHoursIn,
        input  Snooze, Dismiss,
        output AM_PM, Secs_C, Mins_C, Hours_C, Alarm, AlarmId, SnoozeCnt, fsm_state
    );
endinterface

// File: rtl/multi_alarm_clk.sv
// 12-hour HH:MM:SS clock with NUM_ALARMS programmable alarm slots, a bounded ring time,
// and a snooze/dismiss FSM. One second per rising Clock_1sec edge.
module multi_alarm_clk #(
    parameter int NUM_ALARMS  = 4,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_MINS = 5,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic             Clock_1sec,
    input  logic             Reset,
    multi_alarm_clk_if.slave bus
);
    localparam int AW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
    localparam int SW         = ($clog2(MAX_SNOOZE + 1) > 2) ? $clog2(MAX_SNOOZE + 1) : 2;
    localparam int SNZ_CYCLES = SNOOZE_MINS * 60;
    localparam int RW         = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
    localparam int ZW         = (SNZ_CYCLES > 1) ? $clog2(SNZ_CYCLES) : 1;
    localparam logic [RW-1:0] RING_LOAD = RW'(RING_SECS - 1);
    localparam logic [ZW-1:0] SNZ_LOAD  = ZW'(SNZ_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;

    logic          am_pm_q;
    logic [3:0]    hours_q;
    logic [5:0]    mins_q;
    logic [5:0]    secs_q;
    logic          tick_apm;
    logic [3:0]    tick_hours;
    logic [5:0]    tick_mins;
    logic [5:0]    tick_secs;
    logic          set_ok;

    logic          slot_en    [NUM_ALARMS];
    logic          slot_apm   [NUM_ALARMS];
    logic [3:0]    slot_hours [NUM_ALARMS];
    logic [5:0]    slot_mins  [NUM_ALARMS];
    logic          alm_fields_ok;
    logic          alm_en_eff;
    logic          match_hit;
    logic [AW-1:0] match_idx;
    logic          cancel;

    state_t        state_q, state_d;
    logic [RW-1:0] ring_q, ring_d;
    logic [ZW-1:0] snz_q, snz_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [AW-1:0] id_q, id_d;
    logic          alarm_q;

    // Time one second ahead of the current registers; used both to advance and to match.
    always_comb begin
        tick_apm   = am_pm_q;
        tick_hours = hours_q;
        tick_mins  = mins_q;
        tick_secs  = secs_q;
        if (secs_q == 6'd59) begin
            tick_secs = 6'd0;
            if (mins_q == 6'd59) begin
                tick_mins = 6'd0;
                if (hours_q == 4'd12) begin
                    tick_hours = 4'd1;
                end else begin
                    tick_hours = hours_q + 4'd1;
                    if (hours_q == 4'd11) begin
                        tick_apm = ~am_pm_q;
                    end
                end
            end else begin
                tick_mins = mins_q + 6'd1;
            end
        end else begin
            tick_secs = secs_q + 6'd1;
        end
    end

    assign set_ok = (bus.SetSecs <= 6'd59) && (bus.SetMins <= 6'd59) &&
                    (bus.SetHours >= 4'd1) && (bus.SetHours <= 4'd12);

    always_ff @(posedge Clock_1sec) begin
        if (Reset) begin
            am_pm_q <= 1'b0;
            hours_q <= 4'd12;
            mins_q  <= 6'd0;
            secs_q  <= 6'd0;
        end else if (bus.LoadTime && set_ok) begin
            am_pm_q <= bus.Set_AM_PM;
            hours_q <= bus.SetHours;
            mins_q  <= bus.SetMins;
            secs_q  <= bus.SetSecs;
        end else begin
            am_pm_q <= tick_apm;
            hours_q <= tick_hours;
            mins_q  <= tick_mins;
            secs_q  <= tick_secs;
        end
    end

    // A slot written with an illegal hour/minute is stored disabled so it can never fire.
    assign alm_fields_ok = (bus.AlarmMinsIn <= 6'd59) &&
                           (bus.AlarmHoursIn >= 4'd1) && (bus.AlarmHoursIn <= 4'd12);
    assign alm_en_eff    = bus.AlmEnIn && alm_fields_ok;

    always_ff @(posedge Clock_1sec) begin
        if (Reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                slot_en[i]    <= 1'b0;
                slot_apm[i]   <= 1'b0;
                slot_hours[i] <= 4'd0;
                slot_mins[i]  <= 6'd0;
            end
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (bus.LoadAlm && (int'(bus.AlmSel) == i)) begin
                    slot_en[i]    <= alm_en_eff;
                    slot_apm[i]   <= bus.Alarm_AM_PM_In;
                    slot_hours[i] <= bus.AlarmHoursIn;
                    slot_mins[i]  <= bus.AlarmMinsIn;
                end
            end
        end
    end

    // Descending scan so the lowest matching index is the one left in match_idx.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (slot_en[i] && (slot_apm[i] == tick_apm) && (slot_hours[i] == tick_hours) &&
                (slot_mins[i] == tick_mins) && (tick_secs == 6'd0)) begin
                match_hit = 1'b1;
                match_idx = AW'(i);
            end
        end
    end

    assign cancel = bus.LoadAlm && (bus.AlmSel == id_q) && !alm_en_eff;

    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        snz_d   = snz_q;
        scnt_d  = scnt_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.LoadTime && match_hit) begin
                    state_d = ST_RING;
                    ring_d  = RING_LOAD;
                    scnt_d  = '0;
                    id_d    = match_idx;
                end
            end
            ST_RING: begin
                if (cancel || bus.Dismiss) begin
                    state_d = ST_IDLE;
                    scnt_d  = '0;
                end else if (bus.Snooze) begin
                    if (int'(scnt_q) < MAX_SNOOZE) begin
                        state_d = ST_SNOOZE;
                        scnt_d  = scnt_q + SW'(1);
                        snz_d   = SNZ_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        scnt_d  = '0;
                    end
                end else if (ring_q == '0) begin
                    state_d = ST_IDLE;
                    scnt_d  = '0;
                end else begin
                    ring_d = ring_q - RW'(1);
                end
            end
            ST_SNOOZE: begin
                if (cancel || bus.Dismiss) begin
                    state_d = ST_IDLE;
                    scnt_d  = '0;
                end else if (snz_q == '0) begin
                    state_d = ST_RING;
                    ring_d  = RING_LOAD;
                end else begin
                    snz_d = snz_q - ZW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                scnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge Clock_1sec) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            ring_q  <= '0;
            snz_q   <= '0;
            scnt_q  <= '0;
            id_q    <= '0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ring_q  <= ring_d;
            snz_q   <= snz_d;
            scnt_q  <= scnt_d;
            id_q    <= id_d;
            alarm_q <= (state_d == ST_RING);
        end
    end

    assign bus.AM_PM     = am_pm_q;
    assign bus.Hours_C   = hours_q;
    assign bus.Mins_C    = mins_q;
    assign bus.Secs_C    = secs_q;
    assign bus.Alarm     = alarm_q;
    assign bus.AlarmId   = id_q;
    assign bus.SnoozeCnt = scnt_q;
    assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_multi_alarm_clk.sv
// Bench for multi_alarm_clk: directed scenarios plus random traffic, every cycle compared
// against a seconds-of-day reference model through an expected-value queue.
module tb_multi_alarm_clk;
    localparam int NUM_ALARMS  = 4;
    localparam int RING_SECS   = 60;
    localparam int SNOOZE_MINS = 5;
    localparam int MAX_SNOOZE  = 3;
    localparam int SNZ         = SNOOZE_MINS * 60;
    localparam int DAY         = 86400;
    localparam int EW          = 22;
    localparam int M_IDLE = 0, M_RING = 1, M_SNZ = 2;

    logic Clock_1sec = 1'b0;
    logic Reset;
    always #5 Clock_1sec = ~Clock_1sec;

    multi_alarm_clk_if #(.NUM_ALARMS(NUM_ALARMS), .MAX_SNOOZE(MAX_SNOOZE)) bus ();

    multi_alarm_clk #(
        .NUM_ALARMS(NUM_ALARMS), .RING_SECS(RING_SECS),
        .SNOOZE_MINS(SNOOZE_MINS), .MAX_SNOOZE(MAX_SNOOZE)
    ) dut (
        .Clock_1sec(Clock_1sec),
        .Reset(Reset),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_q[$];

    // Reference model: time as seconds since midnight, deadlines as absolute edge numbers.
    int m_t = 0;
    bit m_en [NUM_ALARMS];
    int m_tod[NUM_ALARMS];
    int m_mode = M_IDLE;
    int m_id = 0;
    int m_scnt = 0;
    int edge_n = 0;
    int stop_at = 0;
    int wake_at = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int tod(input int apm, input int h, input int m, input int s);
        return ((h % 12) + (apm != 0 ? 12 : 0)) * 3600 + m * 60 + s;
    endfunction

    function automatic int disp_h(input int t);
        int h24 = t / 3600;
        return (h24 % 12 == 0) ? 12 : h24 % 12;
    endfunction

    function automatic logic [EW-1:0] model_word();
        logic       apm = (m_t / 3600) >= 12;
        logic [3:0] h   = 4'(disp_h(m_t));
        logic [5:0] m   = 6'((m_t / 60) % 60);
        logic [5:0] s   = 6'(m_t % 60);
        return {apm, h, m, s, logic'(m_mode == M_RING), 2'(m_id), 2'(m_scnt)};
    endfunction

    task automatic model_step();
        int  hit;
        bit  fields_ok;
        bit  set_ok;
        bit  cancel;
        edge_n++;
        if (Reset) begin
            m_t = 0;
            m_mode = M_IDLE;
            m_id = 0;
            m_scnt = 0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                m_en[i] = 1'b0;
                m_tod[i] = 0;
            end
            return;
        end
        hit = -1;
        if (!bus.LoadTime)
            for (int i = NUM_ALARMS - 1; i >= 0; i--)
                if (m_en[i] && m_tod[i] == (m_t + 1) % DAY) hit = i;
        fields_ok = (bus.AlarmMinsIn <= 59) && (bus.AlarmHoursIn >= 1) && (bus.AlarmHoursIn <= 12);
        set_ok = (bus.SetSecs <= 59) && (bus.SetMins <= 59) && (bus.SetHours >= 1) && (bus.SetHours <= 12);
        cancel = bus.LoadAlm && (int'(bus.AlmSel) == m_id) && !(bus.AlmEnIn && fields_ok);
        case (m_mode)
            M_IDLE: if (hit >= 0) begin
                m_mode = M_RING; m_id = hit; m_scnt = 0; stop_at = edge_n + RING_SECS;
            end
            M_RING: begin
                if (cancel || bus.Dismiss) begin
                    m_mode = M_IDLE; m_scnt = 0;
                end else if (bus.Snooze) begin
                    if (m_scnt < MAX_SNOOZE) begin
                        m_mode = M_SNZ; m_scnt++; wake_at = edge_n + SNZ;
                    end else begin
                        m_mode = M_IDLE; m_scnt = 0;
                    end
                end else if (edge_n == stop_at) begin
                    m_mode = M_IDLE; m_scnt = 0;
                end
            end
            default: begin
                if (cancel || bus.Dismiss) begin
                    m_mode = M_IDLE; m_scnt = 0;
                end else if (edge_n == wake_at) begin
                    m_mode = M_RING; stop_at = edge_n + RING_SECS;
                end
            end
        endcase
        if (bus.LoadAlm && int'(bus.AlmSel) < NUM_ALARMS) begin
            m_en[bus.AlmSel] = bus.AlmEnIn && fields_ok;
            if (fields_ok) m_tod[bus.AlmSel] = tod(bus.Alarm_AM_PM_In, bus.AlarmHoursIn, bus.AlarmMinsIn, 0);
        end
        if (bus.LoadTime && set_ok) m_t = tod(bus.Set_AM_PM, bus.SetHours, bus.SetMins, bus.SetSecs);
        else m_t = (m_t + 1) % DAY;
    endtask

    task automatic cycle();
        logic       x_apm, x_al;
        logic [3:0] x_h;
        logic [5:0] x_m, x_s;
        logic [1:0] x_id, x_sc;
        @(posedge Clock_1sec);
        model_step();
        exp_q.push_back(model_word());
        @(negedge Clock_1sec);
        {x_apm, x_h, x_m, x_s, x_al, x_id, x_sc} = exp_q.pop_front();
        chk("am_pm", bus.AM_PM, x_apm);
        chk("hours", bus.Hours_C, x_h);
        chk("mins", bus.Mins_C, x_m);
        chk("secs", bus.Secs_C, x_s);
        chk("alarm", bus.Alarm, x_al);
        chk("alarm_id", bus.AlarmId, x_id);
        chk("snooze_cnt", bus.SnoozeCnt, x_sc);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic idle_in();
        bus.LoadTime = 0; bus.Set_AM_PM = 0; bus.SetSecs = 0; bus.SetMins = 0; bus.SetHours = 0;
        bus.LoadAlm = 0; bus.AlmSel = 0; bus.AlmEnIn = 0; bus.Alarm_AM_PM_In = 0;
        bus.AlarmMinsIn = 0; bus.AlarmHoursIn = 0; bus.Snooze = 0; bus.Dismiss = 0;
    endtask

    task automatic do_reset();
        Reset = 1; cycle(); Reset = 0;
    endtask

    task automatic set_time(input int h, input int m, input int s, input int apm);
        bus.LoadTime = 1; bus.SetHours = 4'(h); bus.SetMins = 6'(m); bus.SetSecs = 6'(s);
        bus.Set_AM_PM = 1'(apm);
        cycle();
        bus.LoadTime = 0;
    endtask

    task automatic load_alm(input int sel, input int en, input int apm, input int h, input int m);
        bus.LoadAlm = 1; bus.AlmSel = 2'(sel); bus.AlmEnIn = 1'(en); bus.Alarm_AM_PM_In = 1'(apm);
        bus.AlarmHoursIn = 4'(h); bus.AlarmMinsIn = 6'(m);
        cycle();
        bus.LoadAlm = 0;
    endtask

    task automatic pulse_snooze(input int dis);
        bus.Snooze = 1; bus.Dismiss = 1'(dis); cycle(); bus.Snooze = 0; bus.Dismiss = 0;
    endtask

    task automatic pulse_dismiss();
        bus.Dismiss = 1; cycle(); bus.Dismiss = 0;
    endtask

    initial begin
        int r, k, t;
        Reset = 1;
        idle_in();
        cycle();
        cycle();
        Reset = 0;
        chk("rst_hours", bus.Hours_C, 12);
        chk("rst_mins", bus.Mins_C, 0);
        chk("rst_secs", bus.Secs_C, 0);
        chk("rst_ampm", bus.AM_PM, 0);
        chk("rst_alarm", bus.Alarm, 0);
        chk("rst_id", bus.AlarmId, 0);
        chk("rst_scnt", bus.SnoozeCnt, 0);

        set_time(11, 59, 58, 1);
        run(2);
        chk("wrap_pm_hours", bus.Hours_C, 12);
        chk("wrap_pm_ampm", bus.AM_PM, 0);
        chk("wrap_pm_secs", bus.Secs_C, 0);
        set_time(12, 59, 59, 0);
        run(1);
        chk("wrap12_hours", bus.Hours_C, 1);
        chk("wrap12_ampm", bus.AM_PM, 0);
        chk("wrap12_mins", bus.Mins_C, 0);

        set_time(3, 10, 20, 0);
        set_time(13, 5, 5, 1);
        chk("bad_hour_hours", bus.Hours_C, 3);
        chk("bad_hour_secs", bus.Secs_C, 21);
        set_time(4, 60, 5, 1);
        chk("bad_min_mins", bus.Mins_C, 10);
        chk("bad_min_secs", bus.Secs_C, 22);

        load_alm(0, 1, 0, 7, 30);
        set_time(7, 29, 58, 0);
        run(2);
        chk("ring_alarm", bus.Alarm, 1);
        chk("ring_mins", bus.Mins_C, 30);
        chk("ring_secs", bus.Secs_C, 0);
        chk("ring_id", bus.AlarmId, 0);
        run(RING_SECS - 1);
        chk("ring_last", bus.Alarm, 1);
        run(1);
        chk("autostop_alarm", bus.Alarm, 0);
        chk("autostop_mins", bus.Mins_C, 31);

        do_reset();
        load_alm(1, 1, 0, 7, 30);
        load_alm(3, 1, 0, 7, 30);
        set_time(7, 29, 59, 0);
        run(1);
        chk("prio_id_1", bus.AlarmId, 1);
        pulse_dismiss();
        chk("dismiss_alarm", bus.Alarm, 0);
        load_alm(1, 0, 0, 7, 30);
        set_time(7, 29, 59, 0);
        run(1);
        chk("prio_id_3", bus.AlarmId, 3);
        chk("prio_alarm_3", bus.Alarm, 1);
        pulse_dismiss();

        do_reset();
        load_alm(0, 1, 0, 7, 30);
        set_time(7, 29, 59, 0);
        run(10);
        pulse_snooze(0);
        chk("snz_secs", bus.Secs_C, 10);
        chk("snz_alarm", bus.Alarm, 0);
        chk("snz_cnt1", bus.SnoozeCnt, 1);
        run(SNZ - 1);
        chk("snz_quiet", bus.Alarm, 0);
        run(1);
        chk("rering_alarm", bus.Alarm, 1);
        chk("rering_mins", bus.Mins_C, 35);
        chk("rering_secs", bus.Secs_C, 10);
        chk("rering_cnt", bus.SnoozeCnt, 1);
        for (int n = 2; n <= MAX_SNOOZE; n++) begin
            pulse_snooze(0);
            chk("snz_cnt_n", bus.SnoozeCnt, n);
            run(SNZ);
            chk("rering_n", bus.Alarm, 1);
        end
        pulse_snooze(0);
        chk("snz_max_alarm", bus.Alarm, 0);
        chk("snz_max_cnt", bus.SnoozeCnt, 0);

        set_time(7, 29, 59, 0);
        run(1);
        pulse_snooze(1);
        chk("both_alarm", bus.Alarm, 0);
        chk("both_cnt", bus.SnoozeCnt, 0);
        run(SNZ);
        chk("both_no_rering", bus.Alarm, 0);

        set_time(7, 29, 59, 0);
        run(1);
        set_time(9, 15, 0, 1);
        chk("ring_load_alarm", bus.Alarm, 1);
        chk("ring_load_hours", bus.Hours_C, 9);
        chk("ring_load_ampm", bus.AM_PM, 1);
        pulse_dismiss();

        set_time(7, 29, 59, 0);
        run(1);
        load_alm(0, 0, 0, 7, 30);
        chk("cancel_alarm", bus.Alarm, 0);

        load_alm(0, 1, 0, 7, 30);
        set_time(7, 29, 59, 0);
        run(1);
        pulse_snooze(0);
        run(20);
        do_reset();
        chk("rst_snz_alarm", bus.Alarm, 0);
        chk("rst_snz_hours", bus.Hours_C, 12);
        chk("rst_snz_secs", bus.Secs_C, 0);
        chk("rst_snz_ampm", bus.AM_PM, 0);

        for (int i = 0; i < NUM_ALARMS; i++)
            load_alm(i, 1, $urandom_range(0, 1), $urandom_range(1, 12), $urandom_range(0, 59));
        for (int c = 0; c < 3000; c++) begin
            idle_in();
            r = $urandom_range(0, 999);
            if (r < 8) begin
                k = $urandom_range(0, NUM_ALARMS - 1);
                t = (m_tod[k] - $urandom_range(1, 4) + DAY) % DAY;
                bus.LoadTime = 1; bus.Set_AM_PM = 1'((t / 3600) >= 12);
                bus.SetHours = 4'(disp_h(t)); bus.SetMins = 6'((t / 60) % 60); bus.SetSecs = 6'(t % 60);
            end else if (r < 12) begin
                bus.LoadTime = 1; bus.Set_AM_PM = 1'($urandom_range(0, 1));
                bus.SetHours = 4'($urandom_range(0, 15)); bus.SetMins = 6'($urandom_range(0, 63));
                bus.SetSecs = 6'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 199) == 0) begin
                bus.LoadAlm = 1; bus.AlmSel = 2'($urandom_range(0, NUM_ALARMS - 1));
                bus.AlmEnIn = 1'($urandom_range(0, 3) != 0); bus.Alarm_AM_PM_In = 1'($urandom_range(0, 1));
                bus.AlarmHoursIn = 4'($urandom_range(0, 13)); bus.AlarmMinsIn = 6'($urandom_range(0, 61));
            end
            bus.Snooze = 1'($urandom_range(0, 29) == 0);
            bus.Dismiss = 1'($urandom_range(0, 59) == 0);
            Reset = ($urandom_range(0, 1499) == 0);
            cycle();
        end
        Reset = 0;
        idle_in();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
